// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: 8N1 UART receiver with a runtime-programmable bit period.
// The receiver aligns to the start-bit falling edge, checks the start bit
// at mid-bit, then samples each data bit and the stop bit one full period
// apart. The bit period is captured when the start edge is seen, so
// reprogramming mid-frame only affects the next frame.
module uart_rx_cfg #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          bps_para,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    state_t               state;
    logic                 rx_meta;
    logic                 rxs;
    logic                 rx_prev;
    logic [31:0]          pl_q;
    logic [31:0]          cnt;
    logic [31:0]          half;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 start_edge;

    // Half a bit period; pl_q never drops below 4, so this is at least 2.
    assign half       = pl_q >> 1;
    assign start_edge = rx_prev & ~rxs;

    // Two-flop synchroniser plus one delay stage for edge detection.
    // Reset to the idle-high line level so release never fakes a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rx_prev <= rxs;
        end
    end

    // Frame state machine with registered strobes and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pl_q      <= 32'd4;
            cnt       <= 32'd0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    // Only a real high-to-low transition starts a frame,
                    // so a line stuck low after a bad stop bit is ignored.
                    if (start_edge) begin
                        pl_q    <= (bps_para < 32'd4) ? 32'd4 : bps_para;
                        cnt     <= 32'd0;
                        bit_idx <= '0;
                        busy    <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (cnt == half - 32'd1) begin
                        cnt <= 32'd0;
                        if (!rxs) begin
                            state <= DATA;
                        end else begin
                            // Glitch shorter than half a bit: drop it silently.
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                DATA: begin
                    if (cnt == pl_q - 32'd1) begin
                        cnt     <= 32'd0;
                        // Shift in at the top so the first (LSB) bit ends at bit 0.
                        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_IDX) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                STOP: begin
                    if (cnt == pl_q - 32'd1) begin
                        cnt <= 32'd0;
                        if (rxs) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        // Leaving at mid-stop-bit lets a following start
                        // edge be caught with no idle gap.
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

UART receiver with a baud rate that is set at runtime. It deserialises 8N1 frames from the `rx` pin and delivers each received byte as a one-cycle `rx_valid` strobe. The bit period comes from the `bps_para` input in system clocks per bit, the same encoding used by the transmit-side baud tick generator. The block sits at the serial input of the command SCI and has its own divider: it aligns to the start-bit edge and samples at mid-bit.

## Interface
- `DATA_BITS`, default 8: data bits per frame, sent LSB first; no parity; one stop bit.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `bps_para`, in, 32: clocks per bit (P).
  - Latched into an internal register on start detection.
  - Values below 4 are clamped to 4.
- `rx`, in, 1: asynchronous serial input; idles high.
- `rx_data`, out, DATA_BITS: last good byte; held until the next good frame.
- `rx_valid`, out, 1: one-cycle pulse; `rx_data` is valid in the same cycle.
- `frame_err`, out, 1: one-cycle pulse when the stop bit is sampled low.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- **Synchroniser:** 2-FF on `rx`, both stages reset to 1. A third register `rx_prev` is used for edge detection. All logic uses the synchronised signal `rxs`.
- **State machine:** IDLE, START, DATA, STOP. Reset state is IDLE.
- **IDLE:**
  - A falling edge (`rx_prev`=1, `rxs`=0) latches `Pl` = max(`bps_para`, 4).
  - Clears the bit counter `cnt` and the bit index, then moves to START.
  - A line held low does not retrigger; a high-to-low edge is required.
- **START:**
  - Counts to `H` = `Pl`>>1.
  - Samples `rxs` at `cnt` == `H`-1. If 0, clear `cnt` and go to DATA. If 1, it is a false start: return to IDLE with no output.
- **DATA:**
  - `cnt` counts 0..`Pl`-1 and wraps.
  - At `cnt` == `Pl`-1, shift `rxs` into the shift register at the MSB end, giving LSB-first assembly.
  - After DATA_BITS samples, go to STOP.
- **STOP:**
  - Samples `rxs` at `cnt` == `Pl`-1.
  - If 1: load `rx_data` from the shift register and pulse `rx_valid`.
  - If 0: pulse `frame_err`; `rx_data` is unchanged.
  - Return to IDLE in both cases. IDLE is re-entered at mid-stop-bit, so back-to-back frames are accepted.
- Changes to `bps_para` during a frame are ignored. The new value takes effect at the next start edge.
- `rx_valid` and `frame_err` are never high together.
- **Reset mid-frame:** all state returns to IDLE at once and outputs go to their reset values. The partial frame is discarded.

## Timing
- **Reset values:** `rx_data`=0, `rx_valid`=0, `frame_err`=0, `busy`=0. The synchroniser and `rx_prev` reset to 1.
- **Start detection:** `rx` falls before clock edge k. The falling edge is detected at edge k+2 (2-FF latency), the edge at which `rxs` first reads 0. This is edge E.
- **Sampling points** (counting from E):
  - Start-bit check at E+`H`.
  - Data bit i (i=0..DATA_BITS-1) at E+`H`+(i+1)·`Pl`.
  - Stop bit at E+`H`+(DATA_BITS+1)·`Pl`.
- **Outputs:** `rx_valid`/`frame_err` are registered and high during the cycle after the stop-sample edge, for exactly one cycle.
- **`busy`:** rises the cycle after E and falls together with the `rx_valid`/`frame_err` pulse.
- **Counter:** 32-bit; compares use the latched `Pl`; no overflow is possible.
- **Tolerance:** with P ≥ 16, a transmitter with ±2% clock mismatch decodes correctly.

## Test plan
1. **Basic decode:** P=104; send 0xA5 from an ideal 104-clock transmitter.
   - Exactly one `rx_valid` with `rx_data`=0xA5.
   - The pulse occurs 104·9+52+3 ±1 cycles after the `rx` fall.
   - `frame_err` stays 0.
2. **False start:** P=104; drive `rx` low for 30 cycles, then high.
   - No `rx_valid` and no `frame_err`.
   - `busy` returns to 0 within 55 cycles of the fall.
3. **Framing error:** P=104; send 0x3C after a good 0x11, with the stop bit driven 0.
   - A single `frame_err` pulse and no `rx_valid`.
   - `rx_data` stays 0x11.
   - The line then held low produces nothing further until a high-to-low edge.
4. **Back-to-back:** P=16; send 0x55 then 0xAA with no idle gap.
   - Two `rx_valid` pulses, with `rx_data` 0x55 then 0xAA.
5. **Runtime reconfiguration:** change `bps_para` from 104 to 16 mid-frame.
   - The current frame still decodes at 104.
   - The next frame, sent at 16, decodes correctly.
   - With `bps_para`=2, a frame sent at 4 clocks/bit decodes (clamp).
6. **Reset mid-frame:** assert `rst_n` low during bit 3.
   - All outputs go to their reset values at once.
   - A frame sent after release (0x7E) decodes correctly.
